// File: rtl/i2s_out_tx.sv
`timescale 1ns/1ps
// ============================================================================
// i2s_out_tx -- I2S master transmitter
//
// Output end of the audio path. It pulls stereo words from an upstream FIFO
// over a rts/rtr handshake and generates the bit clock (sck) and word select
// (ws) as I2S master. Each word is serialised MSB-first on sd, with the
// standard one-bit I2S delay.
//
// Frame layout: left = [DATA_SIZE-1:DATA_SIZE/2], right = [DATA_SIZE/2-1:0].
//
// Parameters
//   DATA_SIZE  bits per stereo frame (default 32)
//   CLK_DIV    clk cycles per sck half-period, >= 2 (default 4)
//
// Ports
//   clk            in   master clock, all logic on posedge
//   rst            in   synchronous active-high reset
//   enable         in   run request; only sampled at frame boundaries while running
//   i2s_inp_data   in   stereo word from the FIFO
//   i2s_inp_rts    in   FIFO has a word available
//   i2s_inp_rtr    out  block can accept a word (running, buffer empty)
//   i2s_sck        out  I2S bit clock
//   i2s_ws         out  word select, 0 = left, 1 = right
//   i2s_sd         out  serial data
//   underrun       out  one-clk pulse when a frame starts with no word buffered
//   busy           out  high while running
//
// Build option
//   I2S_OUT_TX_UNDERRUN_REPEAT_EN
//     defined   : an underrun frame repeats the last word that was loaded
//                 from the buffer (zero after reset)
//     undefined : an underrun frame sends all-zero silence
// ============================================================================
module i2s_out_tx #(
    parameter int DATA_SIZE = 32,
    parameter int CLK_DIV   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [DATA_SIZE-1:0] i2s_inp_data,
    input  logic                 i2s_inp_rts,
    output logic                 i2s_inp_rtr,
    output logic                 i2s_sck,
    output logic                 i2s_ws,
    output logic                 i2s_sd,
    output logic                 underrun,
    output logic                 busy
);

    localparam int SLOT_W = (DATA_SIZE > 2) ? $clog2(DATA_SIZE) : 1;
    localparam int DIV_W  = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(DATA_SIZE - 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t               state_reg;
    logic [DIV_W-1:0]     div_cnt_reg;
    logic [SLOT_W-1:0]    slot_reg;
    logic                 sck_reg;
    logic                 ws_reg;
    logic                 underrun_reg;
    logic                 busy_reg;
    // sd is the MSB of the shift register; the register is cleared whenever
    // the block goes idle so sd reads 0 outside RUN.
    logic [DATA_SIZE-1:0] shreg_reg;
    // One-word holding buffer between the FIFO and the shift register.
    logic [DATA_SIZE-1:0] buf_reg;
    logic                 buf_valid_reg;
`ifdef I2S_OUT_TX_UNDERRUN_REPEAT_EN
    logic [DATA_SIZE-1:0] last_word_reg;
`endif

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic                 div_tick;
    logic                 sck_fall;
    logic                 frame_wrap;
    logic                 transfer;
    logic [SLOT_W-1:0]    slot_next;
    logic [DATA_SIZE-1:0] fill_word;

    // ws is high for slots DATA_SIZE/2-1 .. DATA_SIZE-2. Because ws changes
    // on the same falling edge as the slot, it leads each channel's MSB by
    // one bit clock, which is the I2S delay.
    logic [DATA_SIZE-1:0] ws_mask;

    genvar gi;
    generate
        for (gi = 0; gi < DATA_SIZE; gi++) begin : g_ws_mask
            assign ws_mask[gi] = (gi >= DATA_SIZE/2 - 1) && (gi <= DATA_SIZE - 2);
        end
    endgenerate

    always_comb begin
        div_tick   = (div_cnt_reg == DIV_LAST);
        // sck falls on the clk where a high sck is toggled
        sck_fall   = (state_reg == RUN) && div_tick && sck_reg;
        frame_wrap = sck_fall && (slot_reg == LAST_SLOT);
        slot_next  = (slot_reg == LAST_SLOT) ? '0 : slot_reg + 1'b1;
        transfer   = i2s_inp_rts && i2s_inp_rtr;
`ifdef I2S_OUT_TX_UNDERRUN_REPEAT_EN
        fill_word  = last_word_reg;
`else
        fill_word  = '0;
`endif
    end

    // rtr is 0 whenever a word is buffered, so a transfer can never land on
    // the same clk as a frame load that consumes the buffer.
    assign i2s_inp_rtr = (state_reg == RUN) && !buf_valid_reg;

    assign i2s_sck  = sck_reg;
    assign i2s_ws   = ws_reg;
    assign i2s_sd   = shreg_reg[DATA_SIZE-1];
    assign underrun = underrun_reg;
    assign busy     = busy_reg;

    // ------------------------------------------------------------------
    // Control, bit clock and serialiser
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            div_cnt_reg   <= '0;
            slot_reg      <= LAST_SLOT;
            sck_reg       <= 1'b0;
            ws_reg        <= 1'b0;
            underrun_reg  <= 1'b0;
            busy_reg      <= 1'b0;
            shreg_reg     <= '0;
            buf_reg       <= '0;
            buf_valid_reg <= 1'b0;
`ifdef I2S_OUT_TX_UNDERRUN_REPEAT_EN
            last_word_reg <= '0;
`endif
        end else begin
            underrun_reg <= 1'b0;

            if (transfer) begin
                buf_reg       <= i2s_inp_data;
                buf_valid_reg <= 1'b1;
            end

            case (state_reg)
                IDLE: begin
                    // Park at the last slot so the first falling edge after
                    // start wraps to slot 0 and loads a frame.
                    div_cnt_reg <= '0;
                    slot_reg    <= LAST_SLOT;
                    sck_reg     <= 1'b0;
                    ws_reg      <= 1'b0;
                    if (enable) begin
                        state_reg <= RUN;
                        busy_reg  <= 1'b1;
                    end
                end

                RUN: begin
                    if (div_tick) begin
                        div_cnt_reg <= '0;
                        sck_reg     <= ~sck_reg;
                    end else begin
                        div_cnt_reg <= div_cnt_reg + 1'b1;
                    end

                    if (frame_wrap && !enable) begin
                        // Stop only at a frame boundary. A buffered word is
                        // left in place for the next run.
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                        ws_reg    <= 1'b0;
                        shreg_reg <= '0;
                        slot_reg  <= LAST_SLOT;
                    end else if (sck_fall) begin
                        slot_reg <= slot_next;
                        ws_reg   <= ws_mask[slot_next];
                        if (frame_wrap) begin
                            if (buf_valid_reg) begin
                                shreg_reg     <= buf_reg;
                                buf_valid_reg <= 1'b0;
`ifdef I2S_OUT_TX_UNDERRUN_REPEAT_EN
                                last_word_reg <= buf_reg;
`endif
                            end else begin
                                shreg_reg    <= fill_word;
                                underrun_reg <= 1'b1;
                            end
                        end else begin
                            shreg_reg <= shreg_reg << 1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2s_out_tx.sv
`timescale 1ns/1ps
// Testbench for i2s_out_tx (DATA_SIZE=32, CLK_DIV=2).
// A reference model tracks the transmitter by elapsed clk since the run
// started: sck phase, slot number, frame loads and the one-word buffer are
// derived arithmetically and compared with the DUT on every falling clk edge.
module tb_i2s_out_tx;

    localparam int DS        = 32;
    localparam int CD        = 2;
    localparam int FRAME_CLK = DS * 2 * CD;

    logic          clk    = 1'b0;
    logic          rst    = 1'b1;
    logic          enable = 1'b0;
    logic          rts    = 1'b0;
    logic [DS-1:0] data   = '0;
    logic          rtr, sck, ws, sd, underrun, busy;

    i2s_out_tx #(.DATA_SIZE(DS), .CLK_DIV(CD)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .i2s_inp_data (data),
        .i2s_inp_rts  (rts),
        .i2s_inp_rtr  (rtr),
        .i2s_sck      (sck),
        .i2s_ws       (ws),
        .i2s_sd       (sd),
        .underrun     (underrun),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    typedef struct {
        logic [DS-1:0] word;
        int            stamp;   // clk index of the posedge the transfer lands on
    } xfer_t;

    xfer_t         acc_q[$];     // accepted but not yet sent (at most one)
    logic [DS-1:0] src_q[$];     // words the source still has to offer
    bit            src_on     = 1'b0;
    int            hs_count   = 0;
    int            hs_seen    = 0;

    int            cyc        = 0;
    bit            rst_s      = 1'b1;  // rst as sampled at the latest posedge
    bit            en_s       = 1'b0;  // enable as sampled at the latest posedge
    bit            running    = 1'b0;
    int            run_start  = 0;
    int            model_slot = -1;
    logic [DS-1:0] cur_word   = '0;
    logic [DS-1:0] last_word  = '0;
    logic [DS-1:0] frame_bits = '0;
    bit            frame_open = 1'b0;
    bit            frame_ur   = 1'b0;
    logic          exp_ws     = 1'b0;
    logic          exp_sd     = 1'b0;
    logic          exp_ur     = 1'b0;
    int            frames     = 0;

    always @(negedge clk) begin
        int    t;
        int    slot;
        logic  exp_sck;
        xfer_t x;
        cyc++;
        exp_ur  = 1'b0;
        exp_sck = 1'b0;
        slot    = -1;
        if (rst_s) begin
            running    = 1'b0;
            acc_q.delete();
            last_word  = '0;
            exp_ws     = 1'b0;
            exp_sd     = 1'b0;
            frame_open = 1'b0;
            model_slot = -1;
        end else if (!running) begin
            if (en_s) begin
                running    = 1'b1;
                run_start  = cyc;
                exp_ws     = 1'b0;
                exp_sd     = 1'b0;
                model_slot = DS - 1;
            end
        end else begin
            t = cyc - run_start;
            if (t % (2 * CD) == 0) begin
                slot = (t / (2 * CD) - 1) % DS;
                if (slot == 0) begin
                    if (!en_s) begin
                        running    = 1'b0;
                        exp_ws     = 1'b0;
                        exp_sd     = 1'b0;
                        frame_open = 1'b0;
                        slot       = -1;
                        model_slot = -1;
                    end else begin
                        if (acc_q.size() > 0 && acc_q[0].stamp < cyc) begin
                            cur_word  = acc_q[0].word;
                            last_word = cur_word;
                            void'(acc_q.pop_front());
                            frame_ur  = 1'b0;
                        end else begin
                            exp_ur   = 1'b1;
                            frame_ur = 1'b1;
`ifdef I2S_OUT_TX_UNDERRUN_REPEAT_EN
                            cur_word = last_word;
`else
                            cur_word = '0;
`endif
                        end
                        frame_open = 1'b1;
                    end
                end
                if (slot >= 0) begin
                    model_slot = slot;
                    exp_ws     = (slot >= DS/2 - 1) && (slot <= DS - 2);
                    exp_sd     = cur_word[DS-1-slot];
                end
            end
            if (running) exp_sck = ((t / CD) % 2) == 1;
        end

        check("outputs{busy,rtr,sck,ws,sd,underrun}",
              {busy, rtr, sck, ws, sd, underrun},
              {running, running && (acc_q.size() == 0), exp_sck, exp_ws, exp_sd, exp_ur});

        if (slot >= 0 && frame_open) begin
            frame_bits[DS-1-slot] = sd;
            if (slot == DS - 1) begin
                frames++;
                $display("frame %0d: sd word %h, expected %h%s", frames, frame_bits, cur_word,
                         frame_ur ? " (underrun)" : "");
                check("frame_word", frame_bits, cur_word);
            end
        end

        // A handshake seen now completes on the next posedge unless reset wins.
        if (!rst && rts && rtr) begin
            x.word  = data;
            x.stamp = cyc + 1;
            acc_q.push_back(x);
            hs_count++;
            $display("handshake %0d: word %h", hs_count, data);
        end

        rst_s = rst;
        en_s  = enable;
    end

    // ------------------------------------------------------------------
    // Source and stimulus helpers
    // ------------------------------------------------------------------
    task automatic drive_src();
        rts  = src_on && (src_q.size() > 0);
        data = rts ? src_q[0] : DS'($urandom);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
        while (hs_seen < hs_count) begin
            void'(src_q.pop_front());
            hs_seen++;
        end
        drive_src();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_slot(input int s);
        int n = 0;
        while (model_slot != s && n < 4 * FRAME_CLK) begin
            step();
            n++;
        end
        check("wait_slot", 64'(model_slot == s), 64'd1);
    endtask

    task automatic wait_drained();
        int n = 0;
        while (src_q.size() != 0 && n < 4 * FRAME_CLK) begin
            step();
            n++;
        end
        check("src_drained", 64'(src_q.size() == 0), 64'd1);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        // Reset held for 3 clk with enable and rts already high.
        rst    = 1'b1;
        enable = 1'b1;
        rts    = 1'b1;
        data   = 32'hA5A50F0F;
        repeat (3) begin
            @(posedge clk);
            #2;
        end

        // Known pattern first, then three back-to-back words.
        src_q.push_back(32'hA5A50F0F);
        src_q.push_back(32'h00000001);
        src_q.push_back(32'h00000002);
        src_q.push_back(32'h00000003);
        src_on = 1'b1;
        rst    = 1'b0;
        drive_src();
        run(5 * FRAME_CLK + 8);

        // Source dry: an underrun every frame.
        src_on = 1'b0;
        drive_src();
        run(2 * FRAME_CLK);

        // One word, then underrun frames (silence or repeat).
        src_on = 1'b1;
        src_q.push_back(32'h12345678);
        run(3 * FRAME_CLK);

        // Load one word, buffer a second, drop enable mid-frame.
        src_q.push_back(32'h0BADBEEF);
        src_q.push_back(32'hCAFEF00D);
        wait_drained();
        wait_slot(10);
        enable = 1'b0;
        run(2 * FRAME_CLK);

        // Restart: the kept word goes out first; a short enable glitch
        // inside the frame must not stop the run.
        enable = 1'b1;
        wait_slot(8);
        enable = 1'b0;
        run(3);
        enable = 1'b1;
        run(2 * FRAME_CLK);

        // Reset mid-frame with a word buffered; the buffer is discarded.
        src_q.push_back(32'h11111111);
        src_q.push_back(32'h22222222);
        wait_drained();
        wait_slot(20);
        rst = 1'b1;
        step();
        rst = 1'b0;
        run(2 * FRAME_CLK);

        // Randomised traffic with gaps, rare stops and rare resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0 && src_q.size() < 3) src_q.push_back($urandom);
            src_on = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 299) == 0) enable = ~enable;
            rst = ($urandom_range(0, 999) == 0);
            drive_src();
            step();
        end
        rst    = 1'b0;
        enable = 1'b0;
        drive_src();
        run(2 * FRAME_CLK);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
